// File: rtl/test_unit.sv
// Pixel binarizer: thresholds 16 grey-scale bytes per beat into a 16-bit bit-plane
// plus its population count, in a single registered stage with a run-time threshold.
module test_unit #(
    parameter logic [7:0] DEFAULT_THRESH = 8'd128,
    parameter bit         INVERT         = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] in,
    input  logic [63:0] in2,
    input  logic        in_valid,
    input  logic        thr_load,
    input  logic [7:0]  thr_value,
    output logic [15:0] bits,
    output logic [4:0]  ones,
    output logic        out_valid,
    output logic [7:0]  thresh
);

    localparam int unsigned NPIX = 16;
    localparam int unsigned PW   = 8;
    localparam int unsigned CW   = 5;

    logic [NPIX*PW-1:0] w_pixels;
    logic [NPIX-1:0]    w_bits;
    logic [CW-1:0]      w_ones;

    logic [NPIX-1:0]    r_bits;
    logic [CW-1:0]      r_ones;
    logic               r_valid;
    logic [PW-1:0]      r_thresh;

    // Pixels 0..7 come from in, 8..15 from in2, byte k at [8k+7:8k]
    assign w_pixels = {in2, in};

    // Per-pixel unsigned compare against the registered (old) threshold
    always_comb begin
        w_bits = '0;
        for (int j = 0; j < NPIX; j++) begin
            w_bits[j] = (w_pixels[PW*j +: PW] >= r_thresh) ^ INVERT;
        end
    end

    // Popcount of the bit-plane being registered; 16 fits in 5 bits
    always_comb begin
        w_ones = '0;
        for (int j = 0; j < NPIX; j++) begin
            w_ones = w_ones + CW'(w_bits[j]);
        end
    end

    // Result stage: captures only on valid beats, so idle-cycle data is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bits  <= '0;
            r_ones  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_bits <= w_bits;
                r_ones <= w_ones;
            end
        end
    end

    // Threshold register; a load on the same edge as a beat affects only later beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_thresh <= DEFAULT_THRESH;
        end else if (thr_load) begin
            r_thresh <= thr_value;
        end
    end

    assign bits      = r_bits;
    assign ones      = r_ones;
    assign out_valid = r_valid;
    assign thresh    = r_thresh;

endmodule

// File: tb/tb_test_unit.sv
// Self-checking bench for test_unit: directed and randomized beats applied to an
// INVERT=0 and an INVERT=1 instance in parallel, checked against a byte-level model.
module tb_test_unit;

    logic        clk;
    logic        rst_n;
    logic [63:0] in;
    logic [63:0] in2;
    logic        in_valid;
    logic        thr_load;
    logic [7:0]  thr_value;

    logic [15:0] bits0, bits1;
    logic [4:0]  ones0, ones1;
    logic        ov0, ov1;
    logic [7:0]  thr0, thr1;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [7:0]  m_thr;
    logic [15:0] m_bits0, m_bits1;
    logic        m_valid;

    test_unit #(.DEFAULT_THRESH(8'd128), .INVERT(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in(in), .in2(in2), .in_valid(in_valid),
        .thr_load(thr_load), .thr_value(thr_value),
        .bits(bits0), .ones(ones0), .out_valid(ov0), .thresh(thr0)
    );

    test_unit #(.DEFAULT_THRESH(8'd128), .INVERT(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in(in), .in2(in2), .in_valid(in_valid),
        .thr_load(thr_load), .thr_value(thr_value),
        .bits(bits1), .ones(ones1), .out_valid(ov1), .thresh(thr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_bin(input logic [63:0] a, input logic [63:0] b,
                                            input logic [7:0] t, input bit inv);
        logic [7:0]  pix [16];
        logic [15:0] r;
        for (int k = 0; k < 8; k++) begin
            pix[k]     = a[8*k +: 8];
            pix[k + 8] = b[8*k +: 8];
        end
        for (int j = 0; j < 16; j++) begin
            r[j] = inv ? (pix[j] < t) : (pix[j] >= t);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_thr   = 8'd128;
        m_bits0 = '0;
        m_bits1 = '0;
        m_valid = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".bits0"},  32'(bits0), 32'(m_bits0));
        chk({tag, ".bits1"},  32'(bits1), 32'(m_bits1));
        chk({tag, ".ones0"},  32'(ones0), 32'($countones(m_bits0)));
        chk({tag, ".ones1"},  32'(ones1), 32'($countones(m_bits1)));
        chk({tag, ".valid0"}, 32'(ov0),   32'(m_valid));
        chk({tag, ".valid1"}, 32'(ov1),   32'(m_valid));
        chk({tag, ".thr0"},   32'(thr0),  32'(m_thr));
        chk({tag, ".thr1"},   32'(thr1),  32'(m_thr));
    endtask

    // One clock: update the model from the inputs present at the edge, then sample
    task automatic step(input string tag);
        @(posedge clk);
        if (rst_n) begin
            if (in_valid) begin
                m_bits0 = ref_bin(in, in2, m_thr, 1'b0);
                m_bits1 = ref_bin(in, in2, m_thr, 1'b1);
            end
            m_valid = in_valid;
            if (thr_load) m_thr = thr_value;
        end else begin
            model_reset();
        end
        #1;
        compare_all(tag);
    endtask

    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic v,
                         input logic l, input logic [7:0] tv);
        in        = a;
        in2       = b;
        in_valid  = v;
        thr_load  = l;
        thr_value = tv;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        rst_n = 1'b0;
        model_reset();
        drive(rnd64(), rnd64(), 1'b1, 1'b1, 8'($urandom()));

        // Reset held: random valid inputs must not move anything
        for (int i = 0; i < 3; i++) begin
            step("rst_hold");
            drive(rnd64(), rnd64(), 1'b1, 1'b1, 8'($urandom()));
        end
        chk("rst_thresh", 32'(thr0), 32'd128);
        chk("rst_bits",   32'(bits0), 32'd0);

        // Release and first beat at the default threshold
        rst_n = 1'b1;
        drive(64'h807F_FF00_8101_C040, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b0, 8'h00);
        step("first_beat");
        chk("dir_f0aa_bits", 32'(bits0), 32'hF0AA);
        chk("dir_f0aa_ones", 32'(ones0), 32'd8);
        chk("dir_f0aa_inv",  32'(bits1), 32'h0F55);
        chk("dir_f0aa_vld",  32'(ov0),   32'd1);
        drive('0, '0, 1'b0, 1'b0, 8'h00);
        step("idle0");

        // Threshold 0: every pixel passes
        drive('0, '0, 1'b0, 1'b1, 8'h00);
        step("load0");
        drive('0, '0, 1'b1, 1'b0, 8'h00);
        step("thr0_beat");
        chk("thr0_bits",     32'(bits0), 32'hFFFF);
        chk("thr0_ones",     32'(ones0), 32'd16);
        chk("thr0_inv_bits", 32'(bits1), 32'h0000);
        chk("thr0_inv_ones", 32'(ones1), 32'd0);

        // Threshold 255: only a 0xFF pixel passes
        drive('0, '0, 1'b0, 1'b1, 8'hFF);
        step("load255");
        drive(64'h0000_FF00_0000_0000, 64'h0, 1'b1, 1'b0, 8'h00);
        step("thr255_beat");
        chk("thr255_bits",     32'(bits0), 32'h0020);
        chk("thr255_ones",     32'(ones0), 32'd1);
        chk("thr255_inv_bits", 32'(bits1), 32'hFFDF);
        chk("thr255_inv_ones", 32'(ones1), 32'd15);

        // Simultaneous load and beat uses the old threshold
        drive('0, '0, 1'b0, 1'b1, 8'd128);
        step("load128");
        drive({8{8'h90}}, {8{8'h90}}, 1'b1, 1'b1, 8'hA0);
        step("simul_a");
        chk("simul_old_thr", 32'(bits0), 32'hFFFF);
        drive({8{8'h90}}, {8{8'h90}}, 1'b1, 1'b0, 8'h00);
        step("simul_b");
        chk("simul_new_thr", 32'(bits0), 32'h0000);
        chk("simul_thresh",  32'(thr0),  32'hA0);

        // Three back-to-back beats, then idle with held results
        for (int i = 0; i < 3; i++) begin
            drive(rnd64(), rnd64(), 1'b1, 1'b0, 8'h00);
            step("stream");
            chk("stream_vld", 32'(ov0), 32'd1);
        end
        drive('x, 'x, 1'b0, 1'b0, 8'h00);
        step("stream_idle");
        chk("idle_vld", 32'(ov0), 32'd0);
        drive('x, 'x, 1'b0, 1'b0, 8'h00);
        step("stream_idle2");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(rnd64(), rnd64(), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 9) == 0), 8'($urandom()));
            step("rand");
        end

        // Mid-stream asynchronous reset between edges
        drive(rnd64(), rnd64(), 1'b1, 1'b1, 8'h33);
        step("pre_rst");
        chk("pre_rst_vld", 32'(ov0), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        chk("async_rst_thr", 32'(thr1), 32'd128);
        step("rst_low");
        #1;
        rst_n = 1'b1;
        drive(rnd64(), rnd64(), 1'b1, 1'b0, 8'h00);
        step("post_rst");
        chk("post_rst_vld", 32'(ov1), 32'd1);
        drive('0, '0, 1'b0, 1'b0, 8'h00);
        step("final_idle");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/test_unit.md
Name: test_unit

Overview:
- Pixel binarizer for the image-read path: takes 16 grey-scale pixel bytes per beat (two 64-bit words) and produces a 16-bit bit-plane, one bit per pixel, by unsigned threshold compare.
- Also produces the population count of the result.
- Replicated per byte position under the image reader.
- Single registered stage; the threshold can be changed at run time.

Parameters:
- DEFAULT_THRESH, 8'd128: threshold value loaded at reset.
- INVERT, 0: 0 gives bit = (pixel >= threshold); 1 gives bit = (pixel < threshold).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in  input  64  pixels 0..7; pixel k = in[8k+7:8k]
- in2  input  64  pixels 8..15; pixel 8+k = in2[8k+7:8k]
- in_valid  input  1  in/in2 carry a valid beat this cycle
- thr_load  input  1  load thr_value into the threshold register
- thr_value  input  8  new threshold
- bits  output  16  bits[j] = binarized pixel j
- ones  output  5  number of 1s in bits (0..16)
- out_valid  output  1  bits/ones valid
- thresh  output  8  current threshold register value

Behaviour:
- Reset (rst_n low, asynchronous, any time):
  - bits = 16'h0000, ones = 0, out_valid = 0, thresh = DEFAULT_THRESH.
  - Outputs are held at these values while rst_n stays low.
  - Reset takes effect immediately, including mid-stream. The first beat accepted after release is the first beat on which in_valid is sampled high at a rising edge with rst_n high.
- Compare:
  - Unsigned 8-bit compare of each pixel against the threshold register.
  - With INVERT=0, bits[j] = (pixel_j >= thresh). With INVERT=1, bits[j] = (pixel_j < thresh).
  - Boundary, INVERT=0: thresh=0 makes every bit 1; thresh=255 sets a bit only where pixel==255. INVERT=1 gives the complement.
- Latency is 1 cycle:
  - On a rising edge with in_valid=1: bits, ones and out_valid=1 are registered from the current in/in2 and the current thresh.
  - On an edge with in_valid=0: out_valid goes to 0, and bits/ones hold their last values.
  - Back-to-back beats are supported at full rate, one per cycle. There is no backpressure.
- ones: popcount of the value being registered into bits, 5-bit unsigned, registered in the same cycle as bits. The maximum of 16 fits and never wraps.
- Threshold register:
  - On an edge with thr_load=1, thresh <= thr_value.
  - If thr_load and in_valid are both high on the same edge, that beat is compared against the old thresh. The new value applies from the next edge.
- No combinational path from inputs to outputs.
- X on in/in2 while in_valid=0 must not affect the outputs.

Test Plan:
- Reset: hold rst_n=0, drive random inputs with in_valid=1 -> bits=0, ones=0, out_valid=0, thresh=128. Release; first valid beat -> outputs one cycle later.
- Default threshold, INVERT=0: in=64'h80_7F_FF_00_81_01_C0_40, in2=64'hFF_FF_FF_FF_00_00_00_00, in_valid=1 -> next cycle bits=16'hF0AA, ones=8, out_valid=1.
- Threshold boundaries:
  - thr_load with thr_value=0, then all-zero pixels -> bits=16'hFFFF, ones=16.
  - thr_value=255 with only pixel 5 = FF -> bits=16'h0020, ones=1.
- Simultaneous load and data:
  - Setup: thresh=128, all pixels 8'h90.
  - Same edge: thr_load=1 with thr_value=8'hA0, and in_valid=1 -> bits=16'hFFFF.
  - Repeat the beat on the next cycle -> bits=16'h0000.
- Streaming/hold: three consecutive valid beats -> three consecutive out_valid cycles with matching results. Then in_valid=0 -> out_valid=0, and bits/ones hold the third result.
- Mid-stream reset: assert rst_n=0 asynchronously between edges while out_valid=1 -> outputs clear immediately, before the next edge, and thresh returns to 128. Repeat the whole bench with INVERT=1 and check the complemented bits.
